// File: rtl/cart_mbc1_pkg.sv
// Shared definitions for the MBC1 cartridge responder: region decode of the
// console address bus and the encoding of the registered read-source select.
package cart_mbc1_pkg;

  // Source that drives dout during the current clk
  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_ROM  = 2'd1,
    RSEL_RAM  = 2'd2
  } rsel_t;

  // 8 KB windows selected by a[15:13]
  localparam logic [2:0] WIN_RAM_EN = 3'b000;  // 0000-1FFF
  localparam logic [2:0] WIN_BANK5  = 3'b001;  // 2000-3FFF
  localparam logic [2:0] WIN_BANK2  = 3'b010;  // 4000-5FFF
  localparam logic [2:0] WIN_MODE   = 3'b011;  // 6000-7FFF
  localparam logic [2:0] WIN_CRAM   = 3'b101;  // A000-BFFF

  // Magic nibble that enables cart RAM
  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  // Anything below 8000 is ROM (bank 0 or switchable bank)
  function automatic logic is_rom(input logic [15:0] addr);
    return ~addr[15];
  endfunction

  // A000-BFFF is the cart RAM window
  function automatic logic is_cram(input logic [15:0] addr);
    return addr[15:13] == WIN_CRAM;
  endfunction

endpackage

// File: rtl/cart_mbc1.sv
// MBC1 mapper and ROM/RAM front end sitting at the cartridge connector.
// Decodes console writes into bank registers, maps console addresses onto the
// external synchronous ROM/RAM arrays and returns their data one clk later.
module cart_mbc1
  import cart_mbc1_pkg::*;
#(
  parameter int ROM_ADDR_W = 21,
  parameter int RAM_ADDR_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           a,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  cs,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_q,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  input  logic [7:0]            ram_q,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata
);

  logic        ram_en;
  logic [4:0]  bank5;
  logic [1:0]  bank2;
  logic        mode;
  logic        wr_q;
  rsel_t       rsel;
  rsel_t       rsel_next;
  logic        commit;
  logic [4:0]  bank5_eff;
  logic [1:0]  upper_bank;
  logic [20:0] rom_full;
  logic [14:0] ram_full;

  // Reads are qualified only by address; rd is accepted for bus completeness
  logic unused_rd;
  assign unused_rd = rd;

  // A write commits once on the rising edge of the level-sensitive wr strobe
  assign commit = wr & ~wr_q;

  // Bank 0 cannot be selected in the switchable window; only the full zero test applies
  assign bank5_eff  = (bank5 == 5'd0) ? 5'd1 : bank5;
  assign upper_bank = mode ? bank2 : 2'b00;

  // Combinational address mapping, truncated so small arrays mirror
  always_comb begin
    rom_full = {upper_bank, 5'd0, a[13:0]};
    if (a[14]) begin
      rom_full = {bank2, bank5_eff, a[13:0]};
    end
    ram_full = {upper_bank, a[12:0]};
  end

  assign rom_addr  = rom_full[ROM_ADDR_W-1:0];
  assign ram_addr  = ram_full[RAM_ADDR_W-1:0];
  assign ram_wdata = din;

  // RAM write strobe lasts exactly the commit clk and dies with reset
  assign ram_we = commit & is_cram(a) & ram_en & cs & ~rst;

  // Select which array answers the read that the console samples next clk
  always_comb begin
    rsel_next = RSEL_NONE;
    if (is_rom(a)) begin
      rsel_next = RSEL_ROM;
    end else if (is_cram(a) && cs && ram_en) begin
      rsel_next = RSEL_RAM;
    end
  end

  // Bank registers, wr edge history and the read-source pipeline stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en <= 1'b0;
      bank5  <= 5'd0;
      bank2  <= 2'd0;
      mode   <= 1'b0;
      wr_q   <= 1'b0;
      rsel   <= RSEL_NONE;
    end else begin
      wr_q <= wr;
      rsel <= rsel_next;
      if (commit) begin
        case (a[15:13])
          WIN_RAM_EN: ram_en <= (din[3:0] == RAM_EN_KEY);
          WIN_BANK5:  bank5  <= din[4:0];
          WIN_BANK2:  bank2  <= din[1:0];
          WIN_MODE:   mode   <= din[0];
          default:    ;
        endcase
      end
    end
  end

  // Return data from whichever array was addressed last clk; open bus reads FF
  always_comb begin
    dout = 8'hFF;
    case (rsel)
      RSEL_ROM: dout = rom_q;
      RSEL_RAM: dout = ram_q;
      default:  dout = 8'hFF;
    endcase
  end

endmodule
